conv_window_3x3: RTL

- Sliding-window generator that sits directly upstream of the convolution datapath registers.
- Accepts a raster-scan pixel stream (row-major, one signed pixel per handshake) for a fixed IMG_WIDTH x IMG_HEIGHT feature map.
- Uses two internal line buffers plus a 3x3 register array to emit every fully-populated 3x3 window (stride 1, no padding) on a valid/ready output.
- Output feeds the enable-gated window registers of the MAC stage.

---
 rtl/conv_window_3x3.sv | 69 ++++++
 1 files changed

// File: rtl/conv_window_3x3.sv
// conv_window_3x3: raster-stream 3x3 sliding-window generator built from two line buffers and a 3x3 register array
module conv_window_3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [9*DATA_WIDTH-1:0] win_data,
    output logic                    frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int DW = DATA_WIDTH;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [DW-1:0] line_buf0 [IMG_WIDTH];
    logic [DW-1:0] line_buf1 [IMG_WIDTH];
    logic [9*DW-1:0] win, win_next;
    logic accept, emit, col_last, row_last;
    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready;
    assign col_last = col == CW'(IMG_WIDTH - 1);
    assign row_last = row == RW'(IMG_HEIGHT - 1);
    assign emit     = accept && row >= RW'(2) && col >= CW'(2);
    always_comb begin
        win_next = win;
        for (int r = 0; r < 3; r++) begin
            win_next[DW*(3*r)   +: DW] = win[DW*(3*r+1) +: DW];
            win_next[DW*(3*r+1) +: DW] = win[DW*(3*r+2) +: DW];
        end
        win_next[DW*2 +: DW] = line_buf1[col];
        win_next[DW*5 +: DW] = line_buf0[col];
        win_next[DW*8 +: DW] = in_data;
    end
    always_ff @(posedge clock) begin
        if (accept) begin
            win            <= win_next;
            line_buf1[col] <= line_buf0[col];
            line_buf0[col] <= in_data;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && col_last && row_last;
            if (accept) begin
                col <= col_last ? '0 : col + 1'b1;
                row <= col_last ? (row_last ? '0 : row + 1'b1) : row;
            end
            if (emit) begin
                win_valid <= 1'b1;
                win_data  <= win_next;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end
endmodule
